pipe_sequencer: RTL and testbench
=================================

PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 Parameter START_ADDRESS, default 32'h80020000, is the load base address of the first program word.
REQ-002 Parameter MAX_WORDS, default 1024, is the program size limit in words.
REQ-003 Parameter FILL_CYCLES, default 2, is the number of cycles from fetch start to the first valid decode.
REQ-004 clock  in  1  single clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle pulse that begins a load from IDLE or DONE.
REQ-007 ld_valid  in  1  loader word valid.
REQ-008 ld_last  in  1  final program word, qualified by ld_valid.
REQ-009 ld_data  in  32  program word.
REQ-010 ld_ready  out  1  sequencer accepts a loader word.
REQ-011 pc_in  in  32  next PC from fetch.
REQ-012 mem_busy  in  1  main memory busy.
REQ-013 mem_addr / mem_data  out  32 / 32  main memory address and write data.
REQ-014 mem_wren / mem_enable  out  1 / 1  memory write enable and memory enable.
REQ-015 mem_acc_size  out  2  memory access size, constant 2'b00 (word).
REQ-016 stall  out  1  fetch stall.
REQ-017 valid_insn  out  1  decode input valid.
REQ-018 pc_dec  out  32  PC aligned with the instruction entering decode.
REQ-019 word_count  out  16  number of words loaded.
REQ-020 done / error  out  1 / 1  run complete, and load overflow.

Function
REQ-021 State machine SHALL have states IDLE, LOAD, FILL, RUN, DONE.
REQ-022 IDLE SHALL go to LOAD on start, and DONE SHALL go to LOAD on start; entering LOAD SHALL clear word_count, done and error.
REQ-023 In LOAD, ld_ready SHALL equal !mem_busy, and ld_ready SHALL be 0 in every other state.
REQ-024 A handshake (ld_valid & ld_ready) SHALL register mem_addr = START_ADDRESS + 4*word_count, mem_data = ld_data and mem_wren = 1, and SHALL increment word_count.
REQ-025 On cycles without a handshake, mem_wren SHALL be 0 on the next cycle.
REQ-026 A handshake with ld_last=1 SHALL move the FSM to FILL.
REQ-027 A handshake that makes word_count reach MAX_WORDS with ld_last=0 SHALL set error=1 and move the FSM to DONE; the word itself SHALL still be written.
REQ-028 In FILL and RUN, mem_wren SHALL be 0 and mem_addr SHALL register pc_in every cycle in which mem_busy=0.
REQ-029 stall SHALL be combinational: 1 unless state is FILL or RUN, and 1 whenever mem_busy=1.
REQ-030 FILL SHALL last exactly FILL_CYCLES cycles, counted only on cycles with mem_busy=0, then go to RUN.
REQ-031 valid_insn SHALL be 1 exactly in RUN when mem_busy=0.
REQ-032 pc_dec SHALL register the prior mem_addr on each cycle in which mem_busy=0.
REQ-033 An issue counter SHALL clear on FILL entry and SHALL increment on each cycle with valid_insn=1.
REQ-034 When the issue counter reaches word_count, the next state SHALL be DONE.
REQ-035 In DONE, done SHALL be 1, valid_insn SHALL be 0 and stall SHALL be 1.
REQ-036 mem_enable SHALL be 0 in IDLE and 1 in all other states.
REQ-037 start SHALL be ignored in LOAD, FILL and RUN.

Reset
REQ-038 While reset_n=0, independent of clock, the FSM SHALL be in IDLE with these output values:
- mem_addr=START_ADDRESS, mem_data=0, mem_wren=0, mem_enable=0, mem_acc_size=2'b00
- stall=1, valid_insn=0, pc_dec=0, ld_ready=0
- word_count=0, done=0, error=0, issue counter=0, fill counter=0
REQ-039 Reset asserted in any state, including mid-LOAD or mid-RUN, SHALL abort the operation with no further memory write.

Verification
REQ-040 Load: start, then 3 words 32'h20010005, 32'h20020007, 32'h00221820 (last flagged) -> writes at 80020000, 80020004, 80020008; word_count=3; state becomes FILL.
REQ-041 Load gaps: ld_valid low on alternate cycles -> mem_wren=1 only on the cycle after each handshake; addresses remain consecutive.
REQ-042 Run: after REQ-040, pc_in = PC+4 sequence -> stall falls on FILL entry; valid_insn rises 2 cycles later, stays high 3 cycles, then done=1 and stall=1.
REQ-043 Busy: mem_busy=1 for 2 cycles mid-RUN -> stall=1, valid_insn=0, mem_addr and pc_dec held; issue count unchanged; total valid cycles still 3.
REQ-044 Overflow: MAX_WORDS=4, 5 words offered without ld_last -> 4 writes, error=1, done=1, fifth word never accepted.
REQ-045 Reset mid-RUN: reset_n low asynchronously -> all outputs at reset values before the next edge; start after release reloads from START_ADDRESS.

Source files
------------

// File: rtl/pipe_sequencer.sv
// -----------------------------------------------------------------------------
// pipe_sequencer
//
// Loads a program into main memory from a streaming loader, then drives the
// fetch/decode pipeline through a fill phase and a run phase until every loaded
// word has been issued to decode exactly once.
//
// Parameters
//   START_ADDRESS  load base address of the first program word
//   MAX_WORDS      program size limit in words (load overflow beyond this)
//   FILL_CYCLES    non-busy cycles from fetch start to the first valid decode
//                  (must be at least 1)
//
// Ports
//   clock_i          single clock, all state on the rising edge
//   reset_ni         asynchronous active-low reset
//   start_i          one-cycle pulse, begins a load from IDLE or DONE
//   ld_valid_i       loader word valid
//   ld_last_i        final program word (qualified by ld_valid_i)
//   ld_data_i        program word
//   ld_ready_o       sequencer accepts a loader word
//   pc_in_i          next PC from fetch
//   mem_busy_i       main memory busy
//   mem_addr_o       main memory address
//   mem_data_o       main memory write data
//   mem_wren_o       memory write enable
//   mem_enable_o     memory enable
//   mem_acc_size_o   access size, always word (2'b00)
//   stall_o          fetch stall
//   valid_insn_o     decode input valid
//   pc_dec_o         PC aligned with the instruction entering decode
//   word_count_o     number of words loaded
//   done_o           run complete
//   error_o          load overflow
// -----------------------------------------------------------------------------
module pipe_sequencer #(
    parameter logic [31:0] START_ADDRESS = 32'h8002_0000,
    parameter int unsigned MAX_WORDS     = 1024,
    parameter int unsigned FILL_CYCLES   = 2
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic        start_i,
    input  logic        ld_valid_i,
    input  logic        ld_last_i,
    input  logic [31:0] ld_data_i,
    output logic        ld_ready_o,
    input  logic [31:0] pc_in_i,
    input  logic        mem_busy_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        mem_wren_o,
    output logic        mem_enable_o,
    output logic [1:0]  mem_acc_size_o,
    output logic        stall_o,
    output logic        valid_insn_o,
    output logic [31:0] pc_dec_o,
    output logic [15:0] word_count_o,
    output logic        done_o,
    output logic        error_o
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFill,
        StRun,
        StDone
    } state_e;

    localparam int unsigned       FillW    = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
    localparam logic [FillW-1:0]  FillLast = FillW'(FILL_CYCLES - 1);
    localparam logic [15:0]       MaxWords = 16'(MAX_WORDS);

    state_e            state_q, state_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic              mem_wren_q, mem_wren_d;
    logic [31:0]       pc_dec_q, pc_dec_d;
    logic [15:0]       word_count_q, word_count_d;
    logic              error_q, error_d;
    logic [15:0]       issue_q, issue_d;
    logic [FillW-1:0]  fill_q, fill_d;

    logic              run_phase;
    logic              handshake;
    logic [15:0]       wc_inc;
    logic [15:0]       issue_inc;

    // ------------------------------------------------------------------------
    // Combinational outputs
    // ------------------------------------------------------------------------
    assign run_phase      = (state_q == StFill) || (state_q == StRun);
    assign ld_ready_o     = (state_q == StLoad) && !mem_busy_i;
    assign handshake      = ld_valid_i && ld_ready_o;
    assign stall_o        = !run_phase || mem_busy_i;
    assign valid_insn_o   = (state_q == StRun) && !mem_busy_i;
    assign mem_enable_o   = (state_q != StIdle);
    assign done_o         = (state_q == StDone);
    assign mem_acc_size_o = 2'b00;

    assign wc_inc    = word_count_q + 16'd1;
    assign issue_inc = issue_q + {15'd0, valid_insn_o};

    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign mem_wren_o   = mem_wren_q;
    assign pc_dec_o     = pc_dec_q;
    assign word_count_o = word_count_q;
    assign error_o      = error_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_wren_d   = 1'b0;
        pc_dec_d     = pc_dec_q;
        word_count_d = word_count_q;
        error_d      = error_q;
        issue_d      = issue_q;
        fill_d       = fill_q;

        // Decode PC trails the fetch address by one non-busy cycle.
        if (!mem_busy_i) begin
            pc_dec_d = mem_addr_q;
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d      = StLoad;
                    word_count_d = 16'd0;
                    error_d      = 1'b0;
                end
            end

            StLoad: begin
                if (handshake) begin
                    mem_addr_d   = START_ADDRESS + {14'd0, word_count_q, 2'b00};
                    mem_data_d   = ld_data_i;
                    mem_wren_d   = 1'b1;
                    word_count_d = wc_inc;
                    // A final word that also hits the limit is a legal full-size
                    // program, so ld_last takes priority over overflow.
                    if (ld_last_i) begin
                        state_d = StFill;
                        fill_d  = '0;
                        issue_d = 16'd0;
                    end else if (wc_inc == MaxWords) begin
                        state_d = StDone;
                        error_d = 1'b1;
                    end
                end
            end

            StFill: begin
                if (!mem_busy_i) begin
                    mem_addr_d = pc_in_i;
                    if (fill_q == FillLast) begin
                        state_d = StRun;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
            end

            StRun: begin
                if (!mem_busy_i) begin
                    mem_addr_d = pc_in_i;
                    issue_d    = issue_inc;
                    // Leave as soon as the last word is issued so decode sees
                    // each loaded word exactly once.
                    if (issue_inc == word_count_q) begin
                        state_d = StDone;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= StIdle;
            mem_addr_q   <= START_ADDRESS;
            mem_data_q   <= 32'd0;
            mem_wren_q   <= 1'b0;
            pc_dec_q     <= 32'd0;
            word_count_q <= 16'd0;
            error_q      <= 1'b0;
            issue_q      <= 16'd0;
            fill_q       <= '0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_wren_q   <= mem_wren_d;
            pc_dec_q     <= pc_dec_d;
            word_count_q <= word_count_d;
            error_q      <= error_d;
            issue_q      <= issue_d;
            fill_q       <= fill_d;
        end
    end

    // ------------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------------
    a_ready_only_in_load: assert property (
        @(posedge clock_i) disable iff (!reset_ni) ld_ready_o |-> (state_q == StLoad));

    a_write_when_enabled: assert property (
        @(posedge clock_i) disable iff (!reset_ni) mem_wren_q |-> mem_enable_o);

    a_error_only_in_done: assert property (
        @(posedge clock_i) disable iff (!reset_ni) error_q |-> (state_q == StDone));

    a_count_in_range: assert property (
        @(posedge clock_i) disable iff (!reset_ni) word_count_q <= MaxWords);

    a_valid_not_stalled: assert property (
        @(posedge clock_i) disable iff (!reset_ni) valid_insn_o |-> !stall_o);

endmodule

// File: tb/tb_pipe_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pipe_sequencer
//
// Scoreboarded bench for pipe_sequencer. Each accepted loader word pushes its
// expected write (address, data) and its program PC; a negedge monitor pops a
// write on every mem_wren_o and a PC on every valid_insn_o. Directed checks
// cover reset, load, gapped load, fill/run timing, busy hold, overflow and
// asynchronous reset mid-run.
// -----------------------------------------------------------------------------
module tb_pipe_sequencer;

    localparam logic [31:0] Start = 32'h8002_0000;
    localparam int unsigned MaxW  = 4;

    logic        clock_i;
    logic        reset_ni;
    logic        start_i;
    logic        ld_valid_i;
    logic        ld_last_i;
    logic [31:0] ld_data_i;
    logic        ld_ready_o;
    logic [31:0] pc_in_i;
    logic        mem_busy_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_wren_o;
    logic        mem_enable_o;
    logic [1:0]  mem_acc_size_o;
    logic        stall_o;
    logic        valid_insn_o;
    logic [31:0] pc_dec_o;
    logic [15:0] word_count_o;
    logic        done_o;
    logic        error_o;

    pipe_sequencer #(
        .START_ADDRESS (Start),
        .MAX_WORDS     (MaxW),
        .FILL_CYCLES   (2)
    ) dut (
        .clock_i        (clock_i),
        .reset_ni       (reset_ni),
        .start_i        (start_i),
        .ld_valid_i     (ld_valid_i),
        .ld_last_i      (ld_last_i),
        .ld_data_i      (ld_data_i),
        .ld_ready_o     (ld_ready_o),
        .pc_in_i        (pc_in_i),
        .mem_busy_i     (mem_busy_i),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_wren_o     (mem_wren_o),
        .mem_enable_o   (mem_enable_o),
        .mem_acc_size_o (mem_acc_size_o),
        .stall_o        (stall_o),
        .valid_insn_o   (valid_insn_o),
        .pc_dec_o       (pc_dec_o),
        .word_count_o   (word_count_o),
        .done_o         (done_o),
        .error_o        (error_o)
    );

    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    int          n_tests;
    int          n_fail;
    int          n_loaded;
    int          valid_cnt;
    bit          hs;
    logic [63:0] exp_wr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] prog[8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer.
    always @(negedge clock_i) begin
        logic [63:0] e;
        logic [31:0] p;
        if (reset_ni) begin
            if (mem_wren_o) begin
                if (exp_wr_q.size() == 0) begin
                    check("wr_unexpected", 32'(mem_wren_o), 32'd0);
                end else begin
                    e = exp_wr_q.pop_front();
                    check("wr_addr", mem_addr_o, e[63:32]);
                    check("wr_data", mem_data_o, e[31:0]);
                end
            end
            if (valid_insn_o) begin
                valid_cnt++;
                if (exp_pc_q.size() == 0) begin
                    check("issue_unexpected", 32'(valid_insn_o), 32'd0);
                end else begin
                    p = exp_pc_q.pop_front();
                    check("pc_dec", pc_dec_o, p);
                end
            end
        end
    end

    // One clock: detect handshake before the edge (scoreboard producer), and
    // advance the fetch PC whenever fetch was not stalled.
    task automatic step();
        bit adv;
        @(negedge clock_i);
        adv = !stall_o;
        hs  = ld_valid_i && ld_ready_o;
        if (hs) begin
            exp_wr_q.push_back({Start + 32'(n_loaded) * 32'd4, ld_data_i});
            exp_pc_q.push_back(Start + 32'(n_loaded) * 32'd4);
            n_loaded++;
        end
        @(posedge clock_i);
        #1;
        if (adv) pc_in_i = pc_in_i + 32'd4;
    endtask

    task automatic do_start();
        check("drain_wr", 32'(exp_wr_q.size()), 32'd0);
        exp_pc_q.delete();
        n_loaded  = 0;
        valid_cnt = 0;
        pc_in_i   = Start;
        start_i   = 1'b1;
        step();
        start_i   = 1'b0;
        check("load_done_clr", 32'(done_o), 32'd0);
        check("load_err_clr", 32'(error_o), 32'd0);
        check("load_wc_clr", 32'(word_count_o), 32'd0);
        check("load_enable", 32'(mem_enable_o), 32'd1);
    endtask

    task automatic offer(input logic [31:0] data, input bit last, input int bound,
                         output bit acc);
        ld_valid_i = 1'b1;
        ld_data_i  = data;
        ld_last_i  = last;
        acc        = 1'b0;
        for (int i = 0; i < bound && !acc; i++) begin
            step();
            acc = hs;
        end
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
    endtask

    task automatic load_prog(input int n, input bit gaps);
        bit acc;
        for (int i = 0; i < n; i++) begin
            offer(prog[i], (i == n - 1), 20, acc);
            check("load_acc", 32'(acc), 32'd1);
            if (gaps && i != n - 1) step();
        end
    endtask

    task automatic run_to_done(input int bound);
        for (int i = 0; i < bound && !done_o; i++) step();
        check("run_done", 32'(done_o), 32'd1);
    endtask

    task automatic check_reset();
        check("rst_addr", mem_addr_o, Start);
        check("rst_data", mem_data_o, 32'd0);
        check("rst_wren", 32'(mem_wren_o), 32'd0);
        check("rst_enable", 32'(mem_enable_o), 32'd0);
        check("rst_size", 32'(mem_acc_size_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd1);
        check("rst_valid", 32'(valid_insn_o), 32'd0);
        check("rst_pc_dec", pc_dec_o, 32'd0);
        check("rst_ready", 32'(ld_ready_o), 32'd0);
        check("rst_wc", 32'(word_count_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_error", 32'(error_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        n_tests    = 0;
        n_fail     = 0;
        n_loaded   = 0;
        valid_cnt  = 0;
        reset_ni   = 1'b1;
        start_i    = 1'b0;
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
        ld_data_i  = 32'd0;
        pc_in_i    = Start;
        mem_busy_i = 1'b0;
        #1 reset_ni = 1'b0;
        #1 check_reset();
        @(posedge clock_i);
        @(posedge clock_i);
        #1 reset_ni = 1'b1;
        step();
        check("idle_ready", 32'(ld_ready_o), 32'd0);
        check("idle_stall", 32'(stall_o), 32'd1);

        // Basic load of three words, then fill/run timing.
        prog[0] = 32'h2001_0005;
        prog[1] = 32'h2002_0007;
        prog[2] = 32'h0022_1820;
        do_start();
        check("load_ready", 32'(ld_ready_o), 32'd1);
        check("load_stall", 32'(stall_o), 32'd1);
        load_prog(3, 1'b0);
        check("fill_wc", 32'(word_count_o), 32'd3);
        check("fill_last_addr", mem_addr_o, Start + 32'd8);
        check("fill_stall", 32'(stall_o), 32'd0);
        check("fill_ready", 32'(ld_ready_o), 32'd0);
        check("fill_valid0", 32'(valid_insn_o), 32'd0);
        step();
        check("fill_valid1", 32'(valid_insn_o), 32'd0);
        step();
        check("run_valid0", 32'(valid_insn_o), 32'd1);
        step();
        check("run_valid1", 32'(valid_insn_o), 32'd1);
        step();
        check("run_valid2", 32'(valid_insn_o), 32'd1);
        step();
        check("end_done", 32'(done_o), 32'd1);
        check("end_stall", 32'(stall_o), 32'd1);
        check("end_valid", 32'(valid_insn_o), 32'd0);
        check("end_error", 32'(error_o), 32'd0);
        step();
        check("run1_count", 32'(valid_cnt), 32'd3);
        check("run1_pc_left", 32'(exp_pc_q.size()), 32'd0);

        // Full-size program (last word hits the limit) with gaps and busy.
        prog[0] = 32'h1111_0001;
        prog[1] = 32'h2222_0002;
        prog[2] = 32'h3333_0003;
        prog[3] = 32'h4444_0004;
        do_start();
        mem_busy_i = 1'b1;
        ld_valid_i = 1'b1;
        ld_data_i  = prog[0];
        #1;
        check("busy_ready", 32'(ld_ready_o), 32'd0);
        step();
        step();
        check("busy_no_hs", 32'(n_loaded), 32'd0);
        mem_busy_i = 1'b0;
        ld_valid_i = 1'b0;
        load_prog(4, 1'b1);
        check("full_wc", 32'(word_count_o), 32'd4);
        check("full_no_err", 32'(error_o), 32'd0);
        check("full_fill", 32'(stall_o), 32'd0);
        for (int i = 0; i < 10 && !valid_insn_o; i++) step();
        check("run2_first", 32'(valid_insn_o), 32'd1);
        step();
        mem_busy_i = 1'b1;
        #1;
        check("busy_stall", 32'(stall_o), 32'd1);
        check("busy_valid", 32'(valid_insn_o), 32'd0);
        step();
        check("busy_addr", mem_addr_o, Start + 32'd8);
        check("busy_pc_dec", pc_dec_o, Start + 32'd4);
        step();
        check("busy_addr2", mem_addr_o, Start + 32'd8);
        check("busy_pc_dec2", pc_dec_o, Start + 32'd4);
        check("busy_valid2", 32'(valid_insn_o), 32'd0);
        mem_busy_i = 1'b0;
        run_to_done(30);
        step();
        check("run2_count", 32'(valid_cnt), 32'd4);
        check("run2_pc_left", 32'(exp_pc_q.size()), 32'd0);

        // Overflow: five words without ld_last against a four-word limit.
        do_start();
        for (int i = 0; i < 4; i++) begin
            offer(32'hA000_0000 + 32'(i), 1'b0, 20, acc);
            check("ovf_acc", 32'(acc), 32'd1);
        end
        check("ovf_error", 32'(error_o), 32'd1);
        check("ovf_done", 32'(done_o), 32'd1);
        check("ovf_wc", 32'(word_count_o), 32'd4);
        check("ovf_ready", 32'(ld_ready_o), 32'd0);
        offer(32'hA000_0004, 1'b0, 5, acc);
        check("ovf_fifth", 32'(acc), 32'd0);
        check("ovf_loaded", 32'(n_loaded), 32'd4);
        check("ovf_valid", 32'(valid_cnt), 32'd0);

        // Asynchronous reset in the middle of a run, then reload.
        prog[0] = 32'h2001_0005;
        prog[1] = 32'h2002_0007;
        prog[2] = 32'h0022_1820;
        do_start();
        load_prog(3, 1'b0);
        for (int i = 0; i < 10 && !valid_insn_o; i++) step();
        check("rr_running", 32'(valid_insn_o), 32'd1);
        #2 reset_ni = 1'b0;
        #1 check_reset();
        step();
        step();
        exp_pc_q.delete();
        check("rr_no_write", 32'(exp_wr_q.size()), 32'd0);
        reset_ni = 1'b1;
        step();
        do_start();
        load_prog(1, 1'b0);
        check("rr_reload_addr", mem_addr_o, Start);
        run_to_done(20);
        step();
        check("rr_count", 32'(valid_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
